// File: rtl/rtc_calendar_counter.sv
// Real-time clock/calendar: 1 Hz prescaler, full Gregorian carry chain,
// validated load port, HH:MM:SS alarm and one-cycle carry pulses.
module rtc_calendar_counter #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned YEAR_W        = 12,
  parameter int unsigned RESET_YEAR    = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [5:0]        ld_sec,
  input  logic [5:0]        ld_min,
  input  logic [4:0]        ld_hour,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  input  logic              alarm_wr,
  input  logic [5:0]        alarm_sec,
  input  logic [5:0]        alarm_min,
  input  logic [4:0]        alarm_hour,
  input  logic              alarm_en,
  output logic [5:0]        seconds,
  output logic [5:0]        minutes,
  output logic [4:0]        hours,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              sec_pulse,
  output logic              min_pulse,
  output logic              day_pulse,
  output logic              alarm_match,
  output logic              load_err
);

  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    int unsigned v;
    v = 32'(y);
    return ((v % 4) == 0) && (((v % 100) != 0) || ((v % 400) == 0));
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                               input logic [YEAR_W-1:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  logic [PRE_W-1:0]  presc;
  logic [5:0]        al_sec;
  logic [5:0]        al_min;
  logic [4:0]        al_hour;

  logic              tick;
  logic              ld_ok;
  logic              sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap;
  logic              min_carry, hour_carry, day_carry, mon_carry, year_carry;
  logic [5:0]        nxt_sec;
  logic [5:0]        nxt_min;
  logic [4:0]        nxt_hour;
  logic [4:0]        nxt_day;
  logic [3:0]        nxt_month;
  logic [YEAR_W-1:0] nxt_year;
  logic              nxt_alarm;

  // Whole carry chain resolved combinationally so one tick settles in one edge.
  always_comb begin
    tick       = enable && (presc == PRE_MAX);
    sec_wrap   = (seconds == 6'd59);
    min_wrap   = (minutes == 6'd59);
    hour_wrap  = (hours == 5'd23);
    day_wrap   = (day == days_in_month(month, year));
    mon_wrap   = (month == 4'd12);

    min_carry  = sec_wrap;
    hour_carry = min_carry && min_wrap;
    day_carry  = hour_carry && hour_wrap;
    mon_carry  = day_carry && day_wrap;
    year_carry = mon_carry && mon_wrap;

    nxt_sec    = sec_wrap ? 6'd0 : seconds + 6'd1;
    nxt_min    = min_carry ? (min_wrap ? 6'd0 : minutes + 6'd1) : minutes;
    nxt_hour   = hour_carry ? (hour_wrap ? 5'd0 : hours + 5'd1) : hours;
    nxt_day    = day_carry ? (day_wrap ? 5'd1 : day + 5'd1) : day;
    nxt_month  = mon_carry ? (mon_wrap ? 4'd1 : month + 4'd1) : month;
    nxt_year   = year_carry ? year + YEAR_W'(1) : year;

    nxt_alarm  = alarm_en && (nxt_hour == al_hour) && (nxt_min == al_min) &&
                 (nxt_sec == al_sec);

    ld_ok      = (ld_sec <= 6'd59) && (ld_min <= 6'd59) && (ld_hour <= 5'd23) &&
                 (ld_month >= 4'd1) && (ld_month <= 4'd12) && (ld_day != 5'd0) &&
                 (ld_day <= days_in_month(ld_month, ld_year));
  end

  // A valid load wins over a coincident tick; an invalid load only flags load_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      seconds     <= 6'd0;
      minutes     <= 6'd0;
      hours       <= 5'd0;
      day         <= 5'd1;
      month       <= 4'd1;
      year        <= YEAR_W'(RESET_YEAR);
      presc       <= '0;
      al_sec      <= 6'd0;
      al_min      <= 6'd0;
      al_hour     <= 5'd0;
      sec_pulse   <= 1'b0;
      min_pulse   <= 1'b0;
      day_pulse   <= 1'b0;
      alarm_match <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      sec_pulse   <= 1'b0;
      min_pulse   <= 1'b0;
      day_pulse   <= 1'b0;
      alarm_match <= 1'b0;
      load_err    <= 1'b0;

      if (alarm_wr) begin
        al_sec  <= alarm_sec;
        al_min  <= alarm_min;
        al_hour <= alarm_hour;
      end

      if (load && ld_ok) begin
        seconds <= ld_sec;
        minutes <= ld_min;
        hours   <= ld_hour;
        day     <= ld_day;
        month   <= ld_month;
        year    <= ld_year;
        presc   <= '0;
      end else begin
        load_err <= load;
        if (enable) presc <= tick ? '0 : presc + PRE_W'(1);
        if (tick) begin
          seconds     <= nxt_sec;
          minutes     <= nxt_min;
          hours       <= nxt_hour;
          day         <= nxt_day;
          month       <= nxt_month;
          year        <= nxt_year;
          sec_pulse   <= 1'b1;
          min_pulse   <= min_carry;
          day_pulse   <= day_carry;
          alarm_match <= nxt_alarm;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Scoreboard bench for rtc_calendar_counter: directed vectors push expected
// snapshots; a negedge monitor pops and compares whenever the DUT signals an event.
module tb_rtc_calendar_counter;

  localparam int unsigned TPS = 4;
  localparam int unsigned YW  = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [5:0]    ld_sec = '0;
  logic [5:0]    ld_min = '0;
  logic [4:0]    ld_hour = '0;
  logic [4:0]    ld_day = '0;
  logic [3:0]    ld_month = '0;
  logic [YW-1:0] ld_year = '0;
  logic          alarm_wr = 1'b0;
  logic [5:0]    alarm_sec = '0;
  logic [5:0]    alarm_min = '0;
  logic [4:0]    alarm_hour = '0;
  logic          alarm_en = 1'b0;
  logic [5:0]    seconds;
  logic [5:0]    minutes;
  logic [4:0]    hours;
  logic [4:0]    day;
  logic [3:0]    month;
  logic [YW-1:0] year;
  logic          sec_pulse, min_pulse, day_pulse, alarm_match, load_err;

  logic          snap = 1'b0;

  typedef struct packed {
    logic [YW-1:0] y;
    logic [3:0]    mo;
    logic [4:0]    d;
    logic [4:0]    h;
    logic [5:0]    mi;
    logic [5:0]    s;
    logic          sp, mp, dp, am, le;
  } obs_t;

  obs_t  sb[$];
  string nm[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  rtc_calendar_counter #(
    .TICKS_PER_SEC(TPS),
    .YEAR_W(YW),
    .RESET_YEAR(2000)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour), .ld_day(ld_day),
    .ld_month(ld_month), .ld_year(ld_year),
    .alarm_wr(alarm_wr), .alarm_sec(alarm_sec), .alarm_min(alarm_min),
    .alarm_hour(alarm_hour), .alarm_en(alarm_en),
    .seconds(seconds), .minutes(minutes), .hours(hours), .day(day),
    .month(month), .year(year),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .day_pulse(day_pulse),
    .alarm_match(alarm_match), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input obs_t o);
    return $sformatf("%0d-%0d-%0d %0d:%0d:%0d sp=%0b mp=%0b dp=%0b am=%0b le=%0b",
                     o.y, o.mo, o.d, o.h, o.mi, o.s, o.sp, o.mp, o.dp, o.am, o.le);
  endfunction

  function automatic void expect_obs(input string name, input int y, input int mo,
                                     input int d, input int h, input int mi, input int s,
                                     input bit sp, input bit mp, input bit dp,
                                     input bit am, input bit le);
    obs_t o;
    o.y = YW'(y); o.mo = 4'(mo); o.d = 5'(d); o.h = 5'(h); o.mi = 6'(mi); o.s = 6'(s);
    o.sp = sp; o.mp = mp; o.dp = dp; o.am = am; o.le = le;
    sb.push_back(o);
    nm.push_back(name);
  endfunction

  // Monitor: any pulse or a bench snapshot strobe is an observable event.
  always @(negedge clk) begin
    obs_t  got;
    obs_t  exp_o;
    string name;
    if (sec_pulse || min_pulse || day_pulse || alarm_match || load_err || snap) begin
      got = '{year, month, day, hours, minutes, seconds,
              sec_pulse, min_pulse, day_pulse, alarm_match, load_err};
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event at %0t: got %s, required no event", $time, fmt(got));
      end else begin
        exp_o = sb.pop_front();
        name  = nm.pop_front();
        if (got !== exp_o) begin
          n_bad++;
          $display("FAIL %s at %0t: got %s, required %s", name, $time, fmt(got), fmt(exp_o));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    cyc(1);
    snap = 1'b0;
  endtask

  task automatic do_load(input int y, input int mo, input int d, input int h,
                         input int mi, input int s, input bit valid);
    ld_year = YW'(y); ld_month = 4'(mo); ld_day = 5'(d);
    ld_hour = 5'(h); ld_min = 6'(mi); ld_sec = 6'(s);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    if (valid) do_snap();
    else cyc(1);
  endtask

  task automatic tick();
    enable = 1'b1;
    cyc(TPS);
    enable = 1'b0;
  endtask

  task automatic leap_case(input string name, input int y, input int nmo, input int nd);
    expect_obs({name, "_load"}, y, 2, 28, 23, 59, 59, 0, 0, 0, 0, 0);
    do_load(y, 2, 28, 23, 59, 59, 1);
    expect_obs(name, y, nmo, nd, 0, 0, 0, 1, 1, 1, 0, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    reset = 1'b0;
    expect_obs("reset_state", 2000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_snap();

    // Prescaler: 8 enabled cycles give two seconds, then hold while disabled
    expect_obs("run_s1", 2000, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    expect_obs("run_s2", 2000, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    enable = 1'b1;
    cyc(8);
    enable = 1'b0;
    cyc(10);
    expect_obs("hold_s2", 2000, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0);
    do_snap();
    expect_obs("resume_s3", 2000, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0);
    enable = 1'b1; cyc(2);
    enable = 1'b0; cyc(5);
    enable = 1'b1; cyc(2);
    enable = 1'b0; cyc(1);

    // Month/leap carry chain
    leap_case("leap_2024", 2024, 2, 29);
    leap_case("nonleap_2023", 2023, 3, 1);
    leap_case("century_1900", 1900, 3, 1);
    leap_case("quad_century_2000", 2000, 2, 29);
    leap_case("century_2100", 2100, 3, 1);

    // Year rollover and register wrap
    expect_obs("ny_load", 2025, 12, 31, 23, 59, 59, 0, 0, 0, 0, 0);
    do_load(2025, 12, 31, 23, 59, 59, 1);
    expect_obs("new_year_2026", 2026, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0);
    tick();
    expect_obs("wrap_load", 4095, 12, 31, 23, 59, 59, 0, 0, 0, 0, 0);
    do_load(4095, 12, 31, 23, 59, 59, 1);
    expect_obs("year_wrap_0", 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0);
    tick();

    // Invalid loads leave time untouched
    expect_obs("load_feb29_leap", 2024, 2, 29, 6, 7, 8, 0, 0, 0, 0, 0);
    do_load(2024, 2, 29, 6, 7, 8, 1);
    expect_obs("bad_apr31", 2024, 2, 29, 6, 7, 8, 0, 0, 0, 0, 1);
    do_load(2025, 4, 31, 10, 0, 0, 0);
    expect_obs("bad_feb29_2023", 2024, 2, 29, 6, 7, 8, 0, 0, 0, 0, 1);
    do_load(2023, 2, 29, 10, 0, 0, 0);
    expect_obs("bad_month13", 2024, 2, 29, 6, 7, 8, 0, 0, 0, 0, 1);
    do_load(2024, 13, 1, 10, 0, 0, 0);
    expect_obs("bad_sec60", 2024, 2, 29, 6, 7, 8, 0, 0, 0, 0, 1);
    do_load(2024, 1, 1, 0, 0, 60, 0);
    expect_obs("bad_day0", 2024, 2, 29, 6, 7, 8, 0, 0, 0, 0, 1);
    do_load(2024, 1, 0, 0, 0, 0, 0);

    // Load coincident with a tick: load wins, no pulses
    enable = 1'b1;
    cyc(TPS - 1);
    ld_year = YW'(2024); ld_month = 4'd6; ld_day = 5'd15;
    ld_hour = 5'd10; ld_min = 6'd20; ld_sec = 6'd30;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    enable = 1'b0;
    expect_obs("load_beats_tick", 2024, 6, 15, 10, 20, 30, 0, 0, 0, 0, 0);
    do_snap();
    expect_obs("after_load_tick", 2024, 6, 15, 10, 20, 31, 1, 0, 0, 0, 0);
    tick();

    // Alarm
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_sec = 6'd0;
    alarm_wr = 1'b1; cyc(1); alarm_wr = 1'b0;
    alarm_en = 1'b1;
    expect_obs("al_load", 2024, 6, 15, 7, 29, 58, 0, 0, 0, 0, 0);
    do_load(2024, 6, 15, 7, 29, 58, 1);
    expect_obs("al_tick1", 2024, 6, 15, 7, 29, 59, 1, 0, 0, 0, 0);
    tick();
    expect_obs("al_tick2_match", 2024, 6, 15, 7, 30, 0, 1, 1, 0, 1, 0);
    tick();
    alarm_en = 1'b0;
    expect_obs("al_off_load", 2024, 6, 15, 7, 29, 58, 0, 0, 0, 0, 0);
    do_load(2024, 6, 15, 7, 29, 58, 1);
    expect_obs("al_off_tick1", 2024, 6, 15, 7, 29, 59, 1, 0, 0, 0, 0);
    tick();
    expect_obs("al_off_tick2", 2024, 6, 15, 7, 30, 0, 1, 1, 0, 0, 0);
    tick();
    alarm_en = 1'b1;
    expect_obs("al_direct_load", 2024, 6, 15, 7, 30, 0, 0, 0, 0, 0, 0);
    do_load(2024, 6, 15, 7, 30, 0, 1);

    // alarm_wr together with a tick: old alarm still governs that tick
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_sec = 6'd5;
    alarm_wr = 1'b1; cyc(1); alarm_wr = 1'b0;
    expect_obs("awr_load", 2024, 6, 15, 7, 30, 4, 0, 0, 0, 0, 0);
    do_load(2024, 6, 15, 7, 30, 4, 1);
    expect_obs("awr_old_alarm", 2024, 6, 15, 7, 30, 5, 1, 0, 0, 1, 0);
    enable = 1'b1;
    cyc(TPS - 1);
    alarm_sec = 6'd9;
    alarm_wr = 1'b1;
    cyc(1);
    alarm_wr = 1'b0;
    enable = 1'b0;
    expect_obs("awr_load2", 2024, 6, 15, 7, 30, 8, 0, 0, 0, 0, 0);
    do_load(2024, 6, 15, 7, 30, 8, 1);
    expect_obs("awr_new_alarm", 2024, 6, 15, 7, 30, 9, 1, 0, 0, 1, 0);
    tick();

    // Reset overrides load and alarm_wr in the same cycle
    ld_year = YW'(2030); ld_month = 4'd5; ld_day = 5'd5;
    ld_hour = 5'd5; ld_min = 6'd5; ld_sec = 6'd5;
    alarm_hour = 5'd1; alarm_min = 6'd2; alarm_sec = 6'd3;
    reset = 1'b1; load = 1'b1; alarm_wr = 1'b1; enable = 1'b1;
    cyc(1);
    reset = 1'b0; load = 1'b0; alarm_wr = 1'b0; enable = 1'b0;
    expect_obs("reset_override", 2000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_snap();
    expect_obs("post_reset_load", 2000, 1, 1, 23, 59, 59, 0, 0, 0, 0, 0);
    do_load(2000, 1, 1, 23, 59, 59, 1);
    expect_obs("alarm_reset_zero", 2000, 1, 2, 0, 0, 0, 1, 1, 1, 1, 0);
    tick();

    cyc(3);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, next is %s",
               sb.size(), nm[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
